// File: rtl/uart_tx.sv
// Serial transmitter: pops bytes over valid/ready and frames them start/data/[parity]/stop.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int STOP_BITS    = 1,
    parameter int ODD_PARITY   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  tx,
    output logic                  busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_cpb_chk
        $error("uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (ODD_PARITY < 0 || ODD_PARITY > 1) begin : g_par_chk
        $error("uart_tx: ODD_PARITY must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

`ifdef UART_TX_PARITY_EN
    localparam state_t AFTER_DATA = S_PARITY;
`else
    localparam state_t AFTER_DATA = S_STOP;
`endif

    state_t                state;
    state_t                state_d;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_d;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  bit_end;
    logic                  last_stop;
    logic                  take;
    logic                  tx_d;
    logic                  tx_q;
`ifdef UART_TX_PARITY_EN
    logic                  par_q;
`endif

    assign bit_end   = (cnt == CNT_LAST);
    assign last_stop = (state == S_STOP) && (idx == STOP_LAST) && bit_end;
    assign in_ready  = (state == S_IDLE) || last_stop;
    assign take      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        if (state != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt + CW'(1);
        end
        unique case (state)
            S_IDLE: begin
                if (take) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx == DATA_LAST) begin
                        state_d = AFTER_DATA;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx + IW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    idx_d   = '0;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (idx == STOP_LAST) begin
                        // a byte offered in the last stop cycle starts the next frame gaplessly
                        state_d = take ? S_START : S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx + IW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // line level is decoded from the next state so tx leaves a flop
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_q[idx_d];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (take) begin
            data_q <= in_data;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (take) begin
            par_q <= (^in_data) ^ (ODD_PARITY != 0);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= 1'b1;
        end else begin
            tx_q <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state != S_IDLE);

endmodule
